// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor slice processes a/b LSB first,
// one bit per clock, and pulses done when the WIDTH-bit difference is ready.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             load, shift, last;
    logic             d_bit, br_nxt;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bi;
                cnt  <= '0;
            end else if (shift) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
                br      <= br_nxt;
                // Counter parks at WIDTH-1 on the final bit so it never wraps.
                cnt     <= last ? cnt : cnt + CW'(1);
            end
        end
    end

    // The borrow register holds the final borrow-out once the FSM is back in IDLE.
    assign busy = (state == RUN);
    assign diff = diff_sr;
    assign bo   = br;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: an 8-bit instance for directed and
// random operations, and a 3-bit instance for the exhaustive operand sweep.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;
    logic       start3 = 1'b0, bi3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, bo3;
    logic [2:0] diff3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .bo(bo8)
    );

    serial_sub_ctrl #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bi(bi3),
        .busy(busy3), .done(done3), .diff(diff3), .bo(bo3)
    );

    // Reference: plain unsigned arithmetic, result packed as {bo, diff}.
    function automatic logic [8:0] model(input int w, input int av, input int bv, input int biv);
        int r;
        r = (av - bv - biv) & ((1 << w) - 1);
        return {logic'(av < bv + biv), 8'(r)};
    endfunction

    // Drives one 8-bit operation from a negedge; returns the rising edge (counted
    // from the accepting edge 0) at which done is seen high, busy cycles, results,
    // and whether done or diff misbehaved in the cycle after the pulse.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                          output int lat, output int busy_cnt, output logic [7:0] d,
                          output logic o, output logic after_bad);
        a8 = ta; b8 = tb; bi8 = tbi; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        lat = -1; busy_cnt = 0; d = '0; o = 1'b0; after_bad = 1'b1;
        if (busy8) busy_cnt++;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                lat = k + 1; d = diff8; o = bo8;
            end else if (busy8) begin
                busy_cnt++;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            @(negedge clk);
            after_bad = done8 || (diff8 !== d) || (bo8 !== o);
        end
    endtask

    task automatic do_op3(input logic [2:0] ta, input logic [2:0] tb, input logic tbi,
                          output int lat, output logic [2:0] d, output logic o);
        a3 = ta; b3 = tb; bi3 = tbi; start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); bi3 = 1'($urandom);
        lat = -1; d = '0; o = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done3) begin
                lat = k + 1; d = diff3; o = bo3;
            end
        end
    endtask

    task automatic test_reset();
        int lat, bc;
        logic [7:0] d;
        logic o, ab;
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy8, done8, bo8, diff8} !== 11'h0) begin
            bad++; $display("FAIL reset_dut8: got busy=%b done=%b bo=%b diff=%h, want all 0", busy8, done8, bo8, diff8);
        end
        total++;
        if ({busy3, done3, bo3, diff3} !== 6'h0) begin
            bad++; $display("FAIL reset_dut3: got busy=%b done=%b bo=%b diff=%h, want all 0", busy3, done3, bo3, diff3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Start is presented so the first rising edge out of reset accepts it.
        do_op8(8'h5A, 8'h3C, 1'b0, lat, bc, d, o, ab);
        total++;
        if (d !== 8'h1E || o !== 1'b0) begin
            bad++; $display("FAIL basic_result: got diff=%h bo=%b, want diff=1e bo=0", d, o);
        end
        total++;
        if (lat != 9) begin
            bad++; $display("FAIL basic_latency: got edge %0d, want 9", lat);
        end
        total++;
        if (bc != 8) begin
            bad++; $display("FAIL basic_busy: got %0d busy cycles, want 8", bc);
        end
        total++;
        if (ab) begin
            bad++; $display("FAIL basic_after_done: got done/diff/bo change after pulse, want single pulse and held result");
        end
    endtask

    task automatic test_borrow();
        logic [7:0] ta [3] = '{8'h00, 8'h00, 8'hFF};
        logic [7:0] tb [3] = '{8'h01, 8'h00, 8'hFF};
        logic       tbi[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 15; i++) begin
            logic [7:0] xa, xb, d;
            logic xbi, o, ab;
            logic [8:0] exp;
            int lat, bc;
            if (i < 3) begin
                xa = ta[i]; xb = tb[i]; xbi = tbi[i];
            end else begin
                xa = 8'($urandom); xb = 8'($urandom); xbi = 1'($urandom);
            end
            exp = model(8, int'(xa), int'(xb), int'(xbi));
            do_op8(xa, xb, xbi, lat, bc, d, o, ab);
            total++;
            if ({o, d} !== exp || lat != 9) begin
                bad++;
                $display("FAIL borrow_op%0d a=%h b=%h bi=%b: got diff=%h bo=%b edge=%0d, want diff=%h bo=%b edge=9",
                         i, xa, xb, xbi, d, o, lat, exp[7:0], exp[8]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int n_done = 0, done_k = -1;
        logic [7:0] d = '0;
        logic o = 1'b0;
        a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            // Stray starts and operand churn only while the operation is running.
            start8 = (k >= 2 && k <= 6);
            if (k <= 7) begin
                a8 = (k >= 2 && k <= 6) ? 8'hAA : 8'($urandom);
                b8 = (k >= 2 && k <= 6) ? 8'h55 : 8'($urandom);
                bi8 = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                n_done++; done_k = k; d = diff8; o = bo8;
            end
        end
        total++;
        if (n_done != 1 || done_k != 8) begin
            bad++; $display("FAIL ignore_done_count: got %0d pulses (last after edge %0d), want 1 after edge 8", n_done, done_k);
        end
        total++;
        if (d !== 8'h0F || o !== 1'b0) begin
            bad++; $display("FAIL ignore_result: got diff=%h bo=%b, want diff=0f bo=0", d, o);
        end
        total++;
        if (diff8 !== 8'h0F || busy8 !== 1'b0) begin
            bad++; $display("FAIL ignore_hold: got diff=%h busy=%b at end, want diff=0f busy=0", diff8, busy8);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [16:0] ops[N];
        int n_done = 0, cyc = 0, prev = 0;
        for (int i = 0; i < N; i++) ops[i] = 17'($urandom);
        {a8, b8, bi8} = ops[0];
        start8 = 1'b1;
        for (int t = 0; t < 200 && n_done < N; t++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done8) begin
                logic [8:0] exp;
                exp = model(8, int'(ops[n_done][16:9]), int'(ops[n_done][8:1]), int'(ops[n_done][0]));
                total++;
                if ({bo8, diff8} !== exp) begin
                    bad++; $display("FAIL b2b_result%0d: got diff=%h bo=%b, want diff=%h bo=%b", n_done, diff8, bo8, exp[7:0], exp[8]);
                end
                if (n_done > 0) begin
                    total++;
                    if (cyc - prev != 9) begin
                        bad++; $display("FAIL b2b_spacing%0d: got %0d cycles between done, want 9", n_done, cyc - prev);
                    end
                end
                prev = cyc;
                n_done++;
                if (n_done < N) {a8, b8, bi8} = ops[n_done];
                else start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        total++;
        if (n_done != N) begin
            bad++; $display("FAIL b2b_timeout: got %0d results, want %0d", n_done, N);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0, lat, bc;
        logic [7:0] d;
        logic o, ab;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, bo8, diff8} !== 11'h0) begin
            bad++; $display("FAIL midreset_zero: got busy=%b done=%b bo=%b diff=%h, want all 0", busy8, done8, bo8, diff8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 || busy8) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++; $display("FAIL midreset_no_done: got %0d active cycles after release, want 0", n_done);
        end
        do_op8(8'h03, 8'h05, 1'b0, lat, bc, d, o, ab);
        total++;
        if (d !== 8'hFE || o !== 1'b1 || lat != 9) begin
            bad++; $display("FAIL midreset_next_op: got diff=%h bo=%b edge=%0d, want diff=fe bo=1 edge=9", d, o, lat);
        end
    endtask

    task automatic test_sweep3();
        for (int v = 0; v < 128; v++) begin
            logic [6:0] vv;
            logic [2:0] d;
            logic o;
            logic [8:0] exp;
            int lat;
            vv = 7'(v);
            exp = model(3, int'(vv[6:4]), int'(vv[3:1]), int'(vv[0]));
            do_op3(vv[6:4], vv[3:1], vv[0], lat, d, o);
            total++;
            if (d !== exp[2:0] || o !== exp[8] || lat != 4) begin
                bad++;
                $display("FAIL sweep3 a=%0d b=%0d bi=%0d: got diff=%0d bo=%b edge=%0d, want diff=%0d bo=%b edge=4",
                         vv[6:4], vv[3:1], vv[0], d, o, lat, exp[2:0], exp[8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_borrow();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on start acceptance.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on start acceptance.
REQ-007 SHALL have port bi  input  1  borrow-in; captured on start acceptance.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port diff  output  WIDTH  difference result.
REQ-011 SHALL have port bo  output  1  final borrow-out.

Function
REQ-012 SHALL compute the subtraction bit-serially, LSB first, one bit per clock, through a single 1-bit full-subtractor slice: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-013 SHALL implement FSM states IDLE and RUN only; IDLE -> RUN on start=1; RUN -> IDLE after WIDTH bit cycles; no other transitions.
REQ-014 SHALL, on the edge accepting start in IDLE, load the a/b shift registers, load the borrow register with bi, clear the bit counter, and set busy=1.
REQ-015 SHALL, on each RUN edge, shift a and b right by one, shift d into the diff shift register at the MSB, update the borrow register, and increment the bit counter.
REQ-016 SHALL, on the RUN edge processing bit WIDTH-1, return to IDLE, set busy=0, assert done=1 for exactly the following cycle, and present the final diff and bo.
REQ-017 SHALL make done high exactly WIDTH+1 rising edges after the accepting edge, counted from that accepting edge (i.e. on the edge after the last bit edge); the accepting edge is edge 0, the bit edges are 1..WIDTH.
REQ-018 SHALL produce diff = (a - b - bi) mod 2^WIDTH and bo = 1 iff a < b + bi (unsigned).
REQ-019 SHALL hold diff and bo stable from the done pulse until the next accepted start; intermediate shift contents are not required to appear on diff before done.
REQ-020 SHALL ignore start, a, b, bi while busy=1; captured operands are unaffected by input changes during RUN.
REQ-021 SHALL accept a start asserted in the same cycle as done (FSM is in IDLE), giving back-to-back operations with a throughput of one result per WIDTH+1 cycles.
REQ-022 SHALL size the bit counter to hold WIDTH-1 without overflow; no counter wrap SHALL occur within an operation.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, diff=0, bo=0, borrow register=0, counter=0, independent of clk.
REQ-024 SHALL abandon any in-progress operation on reset assertion; no done pulse for it after reset release.
REQ-025 SHALL accept a start on the first rising edge with rst_n=1.

Verification (WIDTH=8 unless stated)
REQ-026 Bench SHALL apply a=0x5A, b=0x3C, bi=0, start for 1 cycle -> busy high for 8 cycles, done pulse 1 cycle, diff=0x1E, bo=0.
REQ-027 Bench SHALL apply a=0x00, b=0x01, bi=0 -> diff=0xFF, bo=1; then a=0x00, b=0x00, bi=1 -> diff=0xFF, bo=1; then a=0xFF, b=0xFF, bi=1 -> diff=0xFF, bo=1.
REQ-028 Bench SHALL start a=0x10, b=0x01, then during RUN pulse start with a=0xAA, b=0x55 and toggle a/b -> single done, diff=0x0F, bo=0, no second operation.
REQ-029 Bench SHALL assert start continuously with new operands presented each done cycle -> done every 9 cycles, each result correct.
REQ-030 Bench SHALL assert rst_n=0 at bit 4 of an operation -> outputs zero immediately, no done after release; next start a=0x03, b=0x05, bi=0 -> diff=0xFE, bo=1.
REQ-031 Bench SHALL, with WIDTH=3, sweep all 128 {a,b,bi} combinations -> every diff/bo matches REQ-018 and done latency matches REQ-017.
